// File: rtl/operand_frame_loader.sv
// operand_frame_loader: packs a byte stream into an operand frame and holds it for the summing array
// Ports: clk; rst (async active-low); s_valid/s_data/s_last/s_ready stream in;
// frame_data/frame_valid/array_run/frame_done to the array; err_short/err_long pulses;
// fill_count slots loaded; frame_sum only when FRAME_CHECKSUM_EN is defined.
module operand_frame_loader #(
  parameter int NUM_OPERANDS = 30,
  parameter int DATA_W = 8,
  parameter int HOLD_CYCLES = 5
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     s_valid,
  input  logic [DATA_W-1:0]                        s_data,
  input  logic                                     s_last,
  output logic                                     s_ready,
  output logic [NUM_OPERANDS*DATA_W-1:0]           frame_data,
  output logic                                     frame_valid,
  output logic                                     array_run,
  output logic                                     frame_done,
  output logic                                     err_short,
  output logic                                     err_long,
`ifdef FRAME_CHECKSUM_EN
  output logic [DATA_W+$clog2(NUM_OPERANDS)-1:0]   frame_sum,
`endif
  output logic [$clog2(NUM_OPERANDS+1)-1:0]        fill_count
);
  localparam int CW = $clog2(NUM_OPERANDS+1);
  localparam int IW = $clog2(NUM_OPERANDS);
  localparam logic [CW-1:0] LAST = CW'(NUM_OPERANDS-1);
  localparam logic [3:0] HLAST = 4'(HOLD_CYCLES-1);
  typedef enum logic [1:0] {FILL, HOLD, DISCARD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] fill_count_q, fill_count_d;
  logic [3:0] hold_q, hold_d;
  logic [DATA_W-1:0] slot_q [NUM_OPERANDS];
  logic [DATA_W-1:0] slot_d [NUM_OPERANDS];
  logic ready_q, ready_d, err_short_q, err_short_d, err_long_q, err_long_d;
  logic acc, last_slot;
  always_comb begin
    acc = s_valid && ready_q;
    last_slot = fill_count_q == LAST;
    state_d = state_q;
    fill_count_d = fill_count_q;
    hold_d = hold_q;
    slot_d = slot_q;
    err_short_d = 1'b0;
    err_long_d = 1'b0;
    if (state_q == FILL && acc) begin
      slot_d[fill_count_q[IW-1:0]] = s_data;
      fill_count_d = fill_count_q + CW'(1);
      if (s_last && !last_slot) begin
        err_short_d = 1'b1;
        fill_count_d = '0;
      end else if (last_slot) begin
        state_d = s_last ? HOLD : DISCARD;
        err_long_d = !s_last;
        fill_count_d = s_last ? fill_count_d : '0;
      end
    end
    if (state_q == DISCARD && acc && s_last) state_d = FILL;
    if (state_q == HOLD) begin
      hold_d = hold_q == HLAST ? 4'd0 : hold_q + 4'd1;
      state_d = hold_q == HLAST ? FILL : HOLD;
      fill_count_d = hold_q == HLAST ? '0 : fill_count_q;
    end
    ready_d = state_d != HOLD;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      fill_count_q <= '0;
      hold_q <= '0;
      ready_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q <= 1'b0;
      for (int i = 0; i < NUM_OPERANDS; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fill_count_q <= fill_count_d;
      hold_q <= hold_d;
      ready_q <= ready_d;
      err_short_q <= err_short_d;
      err_long_q <= err_long_d;
      slot_q <= slot_d;
    end
  end
`ifdef FRAME_CHECKSUM_EN
  localparam int SW = DATA_W + IW;
  logic [SW-1:0] sum_q, sum_d;
  // first slot restarts the sum; any error discards it
  always_comb begin
    sum_d = sum_q;
    if (state_q == FILL && acc) sum_d = (fill_count_q == '0 ? '0 : sum_q) + SW'(s_data);
    if (err_short_d || err_long_d) sum_d = '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum_q <= '0;
    else sum_q <= sum_d;
  end
  assign frame_sum = sum_q;
`endif
  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_pack
    assign frame_data[k*DATA_W +: DATA_W] = slot_q[k];
  end
  assign s_ready = ready_q;
  assign frame_valid = state_q == HOLD;
  assign array_run = state_q == HOLD;
  assign frame_done = state_q == HOLD && hold_q == HLAST;
  assign err_short = err_short_q;
  assign err_long = err_long_q;
  assign fill_count = fill_count_q;
endmodule
